// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
//
// Sequencer and two-way arbiter for the single shared memory port of the
// ld2ud/ciscud datapath. Accesses from the CPU port (fetch/load/store) and the
// E/S port are serialised onto one memory interface. Every access occupies
// ESPERA+1 cycles on the memory side, followed by one FIN cycle (ack) and at
// least one LIBRE cycle before the next grant.
//
// Parameters
//   ANCHO_DIR   address width
//   ANCHO_DATO  data width
//   ESPERA      memory wait states (0..15)
//
// Ports
//   Reloj, Reiniciar          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request, held until cpu_ack
//   cpu_lock                  keep the bus for the CPU after this access
//   cpu_ack, cpu_rdata        CPU completion pulse and registered read data
//   es_req/we/addr/wdata      E/S request, same meaning as the CPU port
//   es_ack, es_rdata          E/S completion pulse and registered read data
//   mem_en, mem_we            memory access active / write strobe
//   mem_addr, mem_wdata       latched address / write data of the owner
//   mem_rdata                 memory read data, valid in the last ACCESO cycle
//   ocupado                   FSM is not in LIBRE
//   concedido                 current/last owner: 0 = CPU, 1 = E/S
// -----------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int ANCHO_DIR  = 16,
    parameter int ANCHO_DATO = 16,
    parameter int ESPERA     = 1
) (
    input  logic                  Reloj,
    input  logic                  Reiniciar,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ANCHO_DIR-1:0]  cpu_addr,
    input  logic [ANCHO_DATO-1:0] cpu_wdata,
    input  logic                  cpu_lock,
    output logic                  cpu_ack,
    output logic [ANCHO_DATO-1:0] cpu_rdata,

    input  logic                  es_req,
    input  logic                  es_we,
    input  logic [ANCHO_DIR-1:0]  es_addr,
    input  logic [ANCHO_DATO-1:0] es_wdata,
    output logic                  es_ack,
    output logic [ANCHO_DATO-1:0] es_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ANCHO_DIR-1:0]  mem_addr,
    output logic [ANCHO_DATO-1:0] mem_wdata,
    input  logic [ANCHO_DATO-1:0] mem_rdata,

    output logic                  ocupado,
    output logic                  concedido
);

    typedef enum logic [1:0] {
        LIBRE  = 2'd0,
        ACCESO = 2'd1,
        FIN    = 2'd2
    } estado_t;

    // Wait-state count loaded into the 4-bit counter at grant time.
    localparam logic [3:0] ESPERA_INI = 4'(ESPERA);

    estado_t    estado;
    estado_t    estadoSig;

    logic [3:0] contador;      // remaining wait states in ACCESO
    logic       duenio;        // owner of the access in flight: 0 CPU, 1 E/S
    logic       ultimo;        // last port that completed an access
    logic       bloqueo;       // CPU holds the bus between accesses
    logic       weLatch;       // latched write flag of the owner

    logic       conceder;      // a grant happens at the end of this LIBRE cycle
    logic       ganador;       // port receiving that grant
    logic       ultimoCiclo;   // current ACCESO cycle is the last one

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            estado <= LIBRE;
        end else begin
            estado <= estadoSig;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, grant decision and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        estadoSig   = estado;
        conceder    = 1'b0;
        ganador     = 1'b0;
        ultimoCiclo = (contador == 4'd0);
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        cpu_ack     = 1'b0;
        es_ack      = 1'b0;
        ocupado     = (estado != LIBRE);
        concedido   = duenio;

        unique case (estado)
            LIBRE: begin
                if (bloqueo) begin
                    // Locked bus: only the CPU may be granted, E/S waits.
                    conceder = cpu_req;
                    ganador  = 1'b0;
                end else if (cpu_req && es_req) begin
                    // Tie: the port that did not go last wins.
                    conceder = 1'b1;
                    ganador  = ~ultimo;
                end else if (cpu_req) begin
                    conceder = 1'b1;
                    ganador  = 1'b0;
                end else if (es_req) begin
                    conceder = 1'b1;
                    ganador  = 1'b1;
                end
                if (conceder) begin
                    estadoSig = ACCESO;
                end
            end

            ACCESO: begin
                mem_en = 1'b1;
                // The strobe lands in the last ACCESO cycle only. It is also
                // masked while reset is asserted so an aborted write never
                // reaches the memory.
                mem_we = weLatch && ultimoCiclo && !Reiniciar;
                if (ultimoCiclo) begin
                    estadoSig = FIN;
                end
            end

            FIN: begin
                cpu_ack   = ~duenio;
                es_ack    = duenio;
                estadoSig = LIBRE;
            end

            default: begin
                estadoSig = LIBRE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counter, ownership, lock and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            contador  <= 4'd0;
            duenio    <= 1'b0;
            ultimo    <= 1'b1;     // CPU wins the first tie after reset
            bloqueo   <= 1'b0;
            weLatch   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            es_rdata  <= '0;
        end else begin
            unique case (estado)
                LIBRE: begin
                    // An idle CPU that no longer asks for the lock releases it.
                    if (!cpu_req && !cpu_lock) begin
                        bloqueo <= 1'b0;
                    end
                    // Request payload is only sampled here; later changes on
                    // the request ports do not disturb the access in flight.
                    if (conceder) begin
                        duenio   <= ganador;
                        contador <= ESPERA_INI;
                        if (ganador) begin
                            weLatch   <= es_we;
                            mem_addr  <= es_addr;
                            mem_wdata <= es_wdata;
                        end else begin
                            weLatch   <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end

                ACCESO: begin
                    if (!ultimoCiclo) begin
                        contador <= contador - 4'd1;
                    end else begin
                        ultimo <= duenio;
                        // Writes leave both read-data registers untouched.
                        if (!weLatch) begin
                            if (duenio) begin
                                es_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                    end
                end

                FIN: begin
                    // The lock follows cpu_lock at the end of each CPU access;
                    // an E/S access can only happen with the lock already clear.
                    bloqueo <= duenio ? 1'b0 : cpu_lock;
                end

                default: begin
                end
            endcase
        end
    end

endmodule
